// File: rtl/intrapred_pkg.sv
// ============================================================================
//  Module      : intrapred_pkg
//  Description : Shared Intra_4x4 luma definitions (mode codes, FSM states,
//                pixel/row/block types, tap filters) for encoder and decoder.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package intrapred_pkg;

   localparam logic [2:0] MODE_V   = 3'd0;
   localparam logic [2:0] MODE_H   = 3'd1;
   localparam logic [2:0] MODE_VL  = 3'd2;
   localparam logic [2:0] MODE_VR  = 3'd3;
   localparam logic [2:0] MODE_HU  = 3'd4;
   localparam logic [2:0] MODE_HD  = 3'd5;
   localparam logic [2:0] MODE_DDL = 3'd6;
   localparam logic [2:0] MODE_DDR = 3'd7;

   typedef logic [7:0]  pix_t;
   typedef pix_t [3:0]  row_t;
   typedef pix_t [15:0] block_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ROW  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      OP_COPY    = 3'd0,
      OP_AVG2    = 3'd1,
      OP_AVG3    = 3'd2,
      OP_HU_END  = 3'd3,
      OP_DDL_END = 3'd4
   } tap_op_t;

   function automatic pix_t tap2(input pix_t x, input pix_t y);
      logic [9:0] s;
      s = {2'b00, x} + {2'b00, y} + 10'd1;
      return s[8:1];
   endfunction

   function automatic pix_t tap3(input pix_t x, input pix_t y, input pix_t z);
      logic [9:0] s;
      s = {2'b00, x} + {1'b0, y, 1'b0} + {2'b00, z} + 10'd2;
      return s[9:2];
   endfunction

endpackage

`default_nettype wire

// File: rtl/intrapred4x4_rowgen.sv
// ============================================================================
//  Module      : intrapred4x4_rowgen
//  Description : Combinational Intra_4x4 predictor producing one row of four
//                pixels for the selected mode and row index.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module intrapred4x4_rowgen
   import intrapred_pkg::*;
(
   input  logic [2:0]      mode,
   input  logic [7:0][7:0] toppixels,
   input  logic [4:0][7:0] leftpixels,
   input  logic [1:0]      row,
   output row_t            pred
);

   // Neighbours laid out as one edge: L,K,J,I,M,A..H at 0..12, zero above.
   logic [15:0][7:0] nbr;
   logic [3:0]       yv;

   assign yv = {2'b00, row};

   always_comb begin
      nbr = '0;
      for (int k = 0; k < 5; k++) nbr[4-k] = leftpixels[k];
      for (int k = 0; k < 8; k++) nbr[5+k] = toppixels[k];
   end

   generate
      for (genvar gx = 0; gx < 4; gx++) begin : g_col
         localparam logic [3:0] XC = 4'(gx);
         localparam logic [3:0] XH = 4'(gx / 2);

         tap_op_t    op;
         logic [3:0] idx;
         logic [3:0] z;

         // Every mode reduces to a copy, 2-tap or 3-tap on the edge array.
         always_comb begin
            op  = OP_AVG3;
            idx = 4'd0;
            z   = 4'd0;
            case (mode)
               MODE_V: begin
                  op  = OP_COPY;
                  idx = 4'd5 + XC;
               end
               MODE_H: begin
                  op  = OP_COPY;
                  idx = 4'd3 - yv;
               end
               MODE_VL: begin
                  op  = row[0] ? OP_AVG3 : OP_AVG2;
                  idx = 4'd5 + XC + {3'b000, row[1]} + {3'b000, row[0]};
               end
               MODE_VR: begin
                  z = {XC[2:0], 1'b0};
                  if (!row[0] && (z >= yv)) begin
                     op  = OP_AVG2;
                     idx = 4'd4 + XC - {3'b000, row[1]};
                  end else if (row[0] && (z + 4'd1 >= yv)) begin
                     idx = 4'd4 + XC - {3'b000, row[1]};
                  end else begin
                     idx = 4'd5 - yv;
                  end
               end
               MODE_HU: begin
                  z = XC + {yv[2:0], 1'b0};
                  if (z > 4'd5) begin
                     op = OP_COPY;
                  end else if (z == 4'd5) begin
                     op = OP_HU_END;
                  end else begin
                     op  = XC[0] ? OP_AVG3 : OP_AVG2;
                     idx = 4'd2 - yv - XH;
                  end
               end
               MODE_HD: begin
                  z = {yv[2:0], 1'b0};
                  if (!XC[0] && (z >= XC)) begin
                     op  = OP_AVG2;
                     idx = 4'd3 + XH - yv;
                  end else if (XC[0] && (z + 4'd1 >= XC)) begin
                     idx = 4'd4 + XH - yv;
                  end else begin
                     idx = 4'd3 + XC;
                  end
               end
               MODE_DDL: begin
                  if ((XC == 4'd3) && (yv == 4'd3)) op = OP_DDL_END;
                  else idx = 4'd6 + XC + yv;
               end
               default: begin
                  idx = 4'd4 + XC - yv;
               end
            endcase
         end

         always_comb begin
            pred[gx] = 8'd0;
            case (op)
               OP_COPY:    pred[gx] = nbr[idx];
               OP_AVG2:    pred[gx] = tap2(nbr[idx], nbr[idx + 4'd1]);
               OP_AVG3:    pred[gx] = tap3(nbr[idx - 4'd1], nbr[idx], nbr[idx + 4'd1]);
               OP_HU_END:  pred[gx] = tap3(nbr[1], nbr[0], nbr[0]);
               OP_DDL_END: pred[gx] = tap3(nbr[11], nbr[12], nbr[12]);
               default:    pred[gx] = 8'd0;
            endcase
         end
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/intrarecon_luma4x4.sv
// ============================================================================
//  Module      : intrarecon_luma4x4
//  Description : 4x4 luma intra reconstruction, one row per cycle, with
//                valid/ready handshakes. Optional INTRARECON_NBR_UPDATE_EN
//                adds next-block neighbour outputs.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module intrarecon_luma4x4
   import intrapred_pkg::*;
#(
   parameter int MB_NUMBER_BITS = 12
)
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [MB_NUMBER_BITS:0] mbnumber_in,
   input  logic [2:0]              mode,
   input  logic [15:0][7:0]        res,
   input  logic [7:0][7:0]         toppixels,
   input  logic [4:0][7:0]         leftpixels,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [MB_NUMBER_BITS:0] mbnumber_out,
   output block_t                  recon
`ifdef INTRARECON_NBR_UPDATE_EN
   ,output row_t                   nbr_top_next
   ,output row_t                   nbr_left_next
`endif
);

   state_t           state;
   state_t           state_nxt;
   logic [1:0]       cnt;
   logic [2:0]       mode_q;
   logic [15:0][7:0] res_q;
   logic [7:0][7:0]  top_q;
   logic [4:0][7:0]  left_q;
   row_t             pred_row;
   row_t             row_recon;
   logic             accept;

   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);
   assign accept    = in_valid && in_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (in_valid)     state_nxt = ST_ROW;
         ST_ROW:  if (cnt == 2'd3)  state_nxt = ST_DONE;
         ST_DONE: if (out_ready)    state_nxt = ST_IDLE;
         default:                   state_nxt = ST_IDLE;
      endcase
   end

   intrapred4x4_rowgen u_rowgen (
      .mode       (mode_q),
      .toppixels  (top_q),
      .leftpixels (left_q),
      .row        (cnt),
      .pred       (pred_row)
   );

   generate
      for (genvar gx = 0; gx < 4; gx++) begin : g_clip
         logic [7:0]        rv;
         logic signed [9:0] sum;
         assign rv  = res_q[{cnt, 2'(gx)}];
         assign sum = $signed({2'b00, pred_row[gx]}) + $signed({{2{rv[7]}}, rv});
         assign row_recon[gx] = sum[9] ? 8'd0 : (sum[8] ? 8'd255 : sum[7:0]);
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt          <= 2'd0;
         mode_q       <= 3'd0;
         res_q        <= '0;
         top_q        <= '0;
         left_q       <= '0;
         recon        <= '0;
         mbnumber_out <= '0;
      end else if (accept) begin
         cnt          <= 2'd0;
         mode_q       <= mode;
         res_q        <= res;
         top_q        <= toppixels;
         left_q       <= leftpixels;
         mbnumber_out <= mbnumber_in;
      end else if (state == ST_ROW) begin
         for (int x = 0; x < 4; x++) recon[{cnt, 2'(x)}] <= row_recon[x];
         cnt <= cnt + 2'd1;
      end
   end

`ifdef INTRARECON_NBR_UPDATE_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         nbr_top_next  <= '0;
         nbr_left_next <= '0;
      end else if (state == ST_ROW) begin
         nbr_left_next[cnt] <= row_recon[3];
         if (cnt == 2'd3) nbr_top_next <= row_recon;
      end
   end
`endif

endmodule

`default_nettype wire

// File: doc/intrarecon_luma4x4.md
INTRARECON_LUMA4X4 -- requirements
Module: intrarecon_luma4x4

Interface
REQ-001 Parameter MB_NUMBER_BITS, default 12, top bit index of the macroblock-number tag.
REQ-002 clk  input  1  sole clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  block descriptor present.
REQ-005 in_ready  output  1  block may be accepted this cycle.
REQ-006 mbnumber_in  input  MB_NUMBER_BITS+1  tag of incoming block.
REQ-007 mode  input  3  0=V, 1=H, 2=VL, 3=VR, 4=HU, 5=HD, 6=DDL, 7=DDR.
REQ-008 res  input  16 x 8 signed  residual, raster order, index = 4*row+col.
REQ-009 toppixels  input  8 x 8  A..H at indices 0..7.
REQ-010 leftpixels  input  5 x 8  M,I,J,K,L at indices 0..4.
REQ-011 out_valid  output  1  reconstructed block present.
REQ-012 out_ready  input  1  consumer accepts block.
REQ-013 mbnumber_out  output  MB_NUMBER_BITS+1  tag of block on recon.
REQ-014 recon  output  16 x 8 unsigned  reconstructed pixels, raster order.

Function
REQ-015 States: IDLE, ROW (row counter 0..3), DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; in_valid&&in_ready at an edge captures mode, res, neighbours, tag and enters ROW with counter 0.
REQ-017 Each ROW cycle SHALL compute and register the 4 pixels of row = counter; counter 3 transitions to DONE.
REQ-018 Latency: capture at edge N, out_valid=1 after edge N+4; recon and mbnumber_out stable while out_valid=1.
REQ-019 In DONE, out_valid&&out_ready at an edge returns to IDLE; out_valid drops; no same-cycle re-accept (one-block bubble).
REQ-020 out_valid=1 without out_ready SHALL hold DONE indefinitely; input changes are ignored.
REQ-021 Prediction per H.264 Intra_4x4 equations for modes 0..7; 3-tap filter (x+2y+z+2)>>2, 2-tap (x+y+1)>>1, computed in 10-bit unsigned.
REQ-022 recon = clip(pred + sign-extended res) to 0..255 using 10-bit signed sum.
REQ-023 in_valid outside IDLE SHALL have no effect; inputs are sampled only at the accept edge.

Reset
REQ-024 reset=1 SHALL immediately force IDLE, counter 0, out_valid 0, recon all 0, mbnumber_out 0, in_ready 1 after release.
REQ-025 reset mid-ROW or in DONE SHALL discard the block; no out_valid pulse follows.

Configuration
REQ-026 Macro INTRARECON_NBR_UPDATE_EN defined: extra outputs nbr_top_next (4 x 8, bottom row of recon) and nbr_left_next (4 x 8, right column of recon), valid with out_valid.
REQ-027 Macro undefined: those ports and their registers SHALL not exist; all other behaviour identical.

Structure
REQ-028 Shared package intrapred_pkg SHALL hold the mode code constants (MODE_V..MODE_DDR), the state enum, and the 4x4 block/row pixel typedefs, shared with the encoder side.
REQ-029 One sub-module, intrapred4x4_rowgen: combinational, given mode, neighbours and row index, returns 4 predicted pixels.

Verification
REQ-030 reset release, A..H=10..17, res all 0, mode 0 -> after 4 cycles recon every row = 10,11,12,13.
REQ-031 mode 1, I,J,K,L=50,60,70,80, res all +5 -> rows 55x4, 65x4, 75x4, 85x4.
REQ-032 mode 0, A..D=250, res all +20 -> recon all 255; A..D=3, res all -10 -> recon all 0.
REQ-033 mode 6, A..H=0,4,8,12,16,20,24,28, res 0 -> recon[0]=4, recon[15]=27 (last uses (G+3H+2)>>2).
REQ-034 out_ready held 0 for 10 cycles after out_valid -> recon and tag unchanged, in_ready 0; out_ready=1 -> IDLE next edge, then back-to-back block with tag 7 appears 4 cycles after its accept.
REQ-035 reset asserted at ROW counter 2 -> out_valid stays 0, in_ready 1 after release, next block reconstructs correctly.
